// File: rtl/prog_loader.sv
// prog_loader: streams a program image from a valid/ready byte source into the cpu ram
// while holding the cpu in reset, then releases the hold and pulses cpu_run.
// Optional feature macro: CHECKSUM_EN. When defined, a trailing check byte must equal the
// running sum (mod 2**DATA_W) of the data bytes, otherwise the session ends in ERR.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_hold,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_FLUSH, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              wren_d, ready_d, hold_d, run_d, busy_d, done_d, err_d;
  logic              xfer;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign xfer = in_valid & in_ready;

  // Next-state and next-output logic; registered outputs follow state_d.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = ram_addr;
    data_d  = ram_data;
    wren_d  = 1'b0;
    run_d   = 1'b0;
    hold_d  = cpu_hold;
    done_d  = done;
    err_d   = err;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          done_d = 1'b0;
          hold_d = 1'b1;
          if (len != '0 && len <= MAX_LEN) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            len_d   = len;
            err_d   = 1'b0;
`ifdef CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = in_data;
          wren_d = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
`ifdef CHECKSUM_EN
          sum_d  = sum_q + in_data;
          if (cnt_q + CNT_ONE == len_q) state_d = S_CHECK;
`else
          if (cnt_q + CNT_ONE == len_q) state_d = S_FLUSH;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        // check byte is consumed but never written to ram
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_FLUSH: begin
        state_d = S_RUN;
        run_d   = 1'b1;
        hold_d  = 1'b0;
      end
      S_RUN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK) ||
              (state_d == S_FLUSH) || (state_d == S_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      in_ready <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      cpu_hold <= 1'b1;
      cpu_run  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      in_ready <= ready_d;
      ram_addr <= addr_d;
      ram_data <= data_d;
      ram_wren <= wren_d;
      cpu_hold <= hold_d;
      cpu_run  <= run_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
`ifdef CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of sessions, randomized sessions against a
// write-list model, and hand sequences for reset, timing and start-while-busy.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [8:0] len_in;
  logic [7:0] in_data;
  logic       in_ready, ram_wren, cpu_hold, cpu_run, busy, done, err;
  logic [7:0] ram_addr, ram_data;

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .cpu_hold(cpu_hold), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  fixed_q[$];
  int run_n, run_cyc, first_wr, last_wr, xfer_cyc;
  logic hold_at_run;
  bit   exp_ok;

  typedef struct {
    int          len;
    logic [15:0] mask;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance to the next falling edge and record what the DUT drives there
  task automatic step();
    @(negedge clk);
    if (ram_wren) begin
      obs_q.push_back({ram_addr, ram_data});
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (cpu_run) begin
      run_n++;
      run_cyc = cyc;
      hold_at_run = cpu_hold;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_ram_wren"}, ram_wren, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_data"}, ram_data, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_cpu_run"},  cpu_run, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_err"},      err, 0);
  endtask

  // One load session. Model: a legal len yields writes (i, byte_i) for i=0..len-1 in order,
  // success unless the check byte is wrong; an illegal len yields no writes and err.
  task automatic run_session(input int l, input logic [15:0] mask, input bit rnd,
                             input int inj_at, input bit bad_ck);
    logic [7:0] bytes[$];
    logic [7:0] sum;
    logic [7:0] b;
    int idx, budget, mism;
    bit legal;
    legal = (l >= 1) && (l <= 256);
    bytes = {};
    exp_q = {};
    sum = 8'h00;
    if (legal) begin
      for (int i = 0; i < l; i++) begin
        b = (fixed_q.size() > 0) ? fixed_q[i] : 8'($urandom);
        bytes.push_back(b);
        exp_q.push_back({8'(i), b});
        sum = sum + b;
      end
`ifdef CHECKSUM_EN
      bytes.push_back(bad_ck ? sum + 8'h01 : sum);
`endif
    end
    exp_ok = legal && !bad_ck;
    obs_q = {};
    run_n = 0; first_wr = -1; last_wr = -1; run_cyc = -1; xfer_cyc = -1;
    start = 1'b1;
    len_in = 9'(l);
    in_valid = 1'($urandom);
    in_data = 8'($urandom);
    step();
    idx = 0;
    budget = 0;
    while (!((done || err) && !busy && idx == bytes.size()) && budget < 3000) begin
      start = 1'b0;
      if (idx < bytes.size()) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : mask[4'(budget % 16)];
        in_data = bytes[idx];
        if (inj_at == idx) begin
          start = 1'b1;
          len_in = 9'd1;
        end
        if (in_valid && in_ready) begin
          if (idx == l - 1) xfer_cyc = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
      end
      step();
      budget++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("session_in_budget", budget < 3000, 1);
    check("write_count", obs_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mism++;
    check("write_content", mism, 0);
    check("cpu_run_pulses", run_n, exp_ok);
    check("done_flag", done, exp_ok);
    check("err_flag", err, !exp_ok);
    check("cpu_hold_end", cpu_hold, !exp_ok);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_off;
`ifdef CHECKSUM_EN
    run_off = 3;
`else
    run_off = 2;
`endif
    vecs[0] = '{3,   16'hFFFF, 3,   1'b1, 1'b0};
    vecs[1] = '{4,   16'hFF59, 4,   1'b1, 1'b0};
    vecs[2] = '{0,   16'hFFFF, 0,   1'b0, 1'b1};
    vecs[3] = '{257, 16'hFFFF, 0,   1'b0, 1'b1};
    vecs[4] = '{1,   16'hAAAA, 1,   1'b1, 1'b0};
    vecs[5] = '{256, 16'hFFFF, 256, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; len_in = 9'd0; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    in_valid = 1'b1;
    step();
    check("idle_no_consume", ram_wren, 0);

    // table-driven sessions
    for (int i = 0; i < 6; i++) begin
      run_session(vecs[i].len, vecs[i].mask, 1'b0, (vecs[i].len == 256) ? 100 : -1, 1'b0);
      check("tbl_writes", obs_q.size(), vecs[i].exp_writes);
      check("tbl_done", done, vecs[i].exp_done);
      check("tbl_err", err, vecs[i].exp_err);
      if (vecs[i].len == 3) begin
        check("b2b_write_span", last_wr - first_wr, 2);
        check("run_after_last_xfer", run_cyc - xfer_cyc, run_off);
        check("hold_falls_with_run", hold_at_run, 0);
      end
      if (vecs[i].len == 4) check("gap_write_span", last_wr - first_wr, 6);
    end

    // rst mid-session aborts the load
    step();
    start = 1'b1; len_in = 9'd5; step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; step();
    in_data = 8'h6B; step();
    rst = 1'b1; step();
    rst = 1'b0; in_valid = 1'b1;
    check_reset_values("midrst");
    step();
    check("midrst_no_write", ram_wren, 0);
    in_valid = 1'b0;
    run_session(1, 16'hFFFF, 1'b0, -1, 1'b0);

    // rst and start in the same cycle: rst wins
    rst = 1'b1; start = 1'b1; len_in = 9'd3; step();
    rst = 1'b0; start = 1'b0; step();
    check("rst_beats_start_busy", busy, 0);
    check("rst_beats_start_ready", in_ready, 0);

`ifdef CHECKSUM_EN
    fixed_q = {8'hF0, 8'h20};
    run_session(2, 16'hFFFF, 1'b0, -1, 1'b0);
    run_session(2, 16'hFFFF, 1'b0, -1, 1'b1);
    fixed_q = {};
`endif

    // randomized sessions against the model
    for (int k = 0; k < 20; k++) begin
      int l;
      l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(1, 40));
`ifdef CHECKSUM_EN
      run_session(l, 16'hFFFF, 1'b1, -1, 1'($urandom_range(0, 1)));
`else
      run_session(l, 16'hFFFF, 1'b1, -1, 1'b0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
